// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity helper and
// parameter legality checks used by the RX block and its TX successor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int PAR_W = 16;

    // Callers zero-extend narrower words, so unused upper bits do not disturb the XOR.
    function automatic logic parity_calc(input logic [PAR_W-1:0] i_data);
        return ^i_data;
    endfunction

    function automatic bit data_bits_ok(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

    function automatic bit stop_bits_ok(input int n);
        return (n == 1) || (n == 2);
    endfunction

    function automatic bit oversample_ok(input int n);
        return (n >= 4) && ((n % 2) == 0);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs (RXD, CTS, RTS).
// RESET_VAL lets idle-high and idle-low lines come out of reset inactive.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: configurable width, optional parity, 1/2 stop bits.
// state      | meaning
// IDLE       | line idle, waiting for a low sample on a tick
// START      | validating start bit at its centre (glitch -> IDLE)
// DATA       | sampling DATA_BITS bit centres, LSB first
// PARITY     | sampling parity bit centre
// STOP       | sampling stop bit centre(s); last centre completes the frame
// WAIT_HIGH  | after framing error, hold off until the line returns high
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_tick,
    input  logic                 i_rxd,
    input  logic                 i_rx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST      = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD     = (PARITY_ODD != 0);

    generate
        if (!data_bits_ok(DATA_BITS) || !stop_bits_ok(STOP_BITS) || !oversample_ok(OVERSAMPLE)) begin : g_bad_cfg
            $error("uart_rx_ovs: illegal DATA_BITS, STOP_BITS or OVERSAMPLE");
        end
    endgenerate

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 w_rxd_s;
    logic [TW-1:0]        r_tcnt;
    logic [BW-1:0]        r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 w_mid;
    logic                 w_bit_end;
    logic                 w_done;
    logic                 w_ferr_nxt;
    logic                 w_perr_calc;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync_rxd (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_rxd),
        .o_q   (w_rxd_s)
    );

    assign w_mid       = i_tick && (r_tcnt == T_HALF);
    assign w_bit_end   = i_tick && (r_tcnt == T_LAST);
    assign w_ferr_nxt  = r_ferr | ~w_rxd_s;
    assign w_perr_calc = (parity_calc(PAR_W'(r_shift)) ^ w_rxd_s) != PAR_ODD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (i_tick && !w_rxd_s) w_state_nxt = ST_START;
            ST_START:     if (w_mid) w_state_nxt = w_rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_bit_end && (r_bcnt == B_LAST_DATA))
                              w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (w_bit_end) w_state_nxt = ST_STOP;
            ST_STOP:      if (w_bit_end && (r_bcnt == B_LAST_STOP))
                              w_state_nxt = w_ferr_nxt ? ST_WAIT_HIGH : ST_IDLE;
            ST_WAIT_HIGH: if (i_tick && w_rxd_s) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != ST_IDLE);
        w_done = (r_state == ST_STOP) && w_bit_end && (r_bcnt == B_LAST_STOP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else if (i_tick) begin
            case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    r_bcnt <= '0;
                    r_perr <= 1'b0;
                    r_ferr <= 1'b0;
                end
                ST_START: r_tcnt <= w_mid ? '0 : r_tcnt + 1'b1;
                ST_DATA: begin
                    r_tcnt <= w_bit_end ? '0 : r_tcnt + 1'b1;
                    if (w_bit_end) begin
                        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= (r_bcnt == B_LAST_DATA) ? '0 : r_bcnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    r_tcnt <= w_bit_end ? '0 : r_tcnt + 1'b1;
                    if (w_bit_end) r_perr <= w_perr_calc;
                end
                ST_STOP: begin
                    r_tcnt <= w_bit_end ? '0 : r_tcnt + 1'b1;
                    if (w_bit_end) begin
                        r_ferr <= w_ferr_nxt;
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: r_tcnt <= '0;
            endcase
        end
    end

    // A consumer handshake in the completion cycle frees the holding slot for the new word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (w_done && (!o_rx_valid || i_rx_ready)) begin
                o_rx_data    <= r_shift;
                o_rx_valid   <= 1'b1;
                o_parity_err <= r_perr;
                o_frame_err  <= w_ferr_nxt;
            end else begin
                if (w_done)     o_overrun  <= 1'b1;
                if (i_rx_ready) o_rx_valid <= 1'b0;
            end
        end
    end

endmodule
